// File: rtl/bus_rr_pkg.sv
// Shared types and width helpers for the round-robin bus crossbar.
// Hosts and devices are identified by idx_t; the error pseudo-target sits
// just past the last real device (index NrDevices).
package bus_rr_pkg;

    // Wide enough for up to 255 hosts or devices plus the error pseudo-target
    localparam int unsigned IdxWidth = 8;

    typedef logic [IdxWidth-1:0] idx_t;

    // One outstanding request: who asked, and which target owes the answer
    typedef struct packed {
        idx_t host;
        idx_t target;
    } out_entry_t;

    // Index width that stays legal for a single-element range
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Counter width able to hold the value n itself
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    // The error pseudo-target is numbered right after the last device
    function automatic int unsigned err_target(input int unsigned nr_devices);
        return nr_devices;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first requester after the last winner.
// The pointer only moves when the caller reports that the pick was used.
module rr_arbiter
    import bus_rr_pkg::*;
#(
    parameter int unsigned NrHosts = 2
) (
    input  logic                           clk_sys_i,
    input  logic                           rst_sys_ni,
    input  logic [NrHosts-1:0]             req,
    input  logic                           advance,
    output logic [NrHosts-1:0]             gnt,
    output logic [idx_width(NrHosts)-1:0]  idx,
    output logic                           valid
);

    localparam int unsigned HostW = idx_width(NrHosts);

    logic [HostW-1:0] ptr_q;
    logic [HostW-1:0] win;
    logic             found;
    int unsigned      cand;

    // Search from ptr+1 with wrap-around; first requester found wins
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = 0;
        for (int unsigned i = 1; i <= NrHosts; i++) begin
            cand = (32'(ptr_q) + i) % NrHosts;
            if (!found && req[HostW'(cand)]) begin
                found = 1'b1;
                win   = HostW'(cand);
            end
        end
    end

    // One-hot view of the pick
    always_comb begin
        gnt = '0;
        if (found) begin
            gnt[win] = 1'b1;
        end
    end

    assign idx   = win;
    assign valid = found;

    // Reset pointer to the last host so host 0 has first priority
    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            ptr_q <= HostW'(NrHosts - 1);
        end else if (advance && found) begin
            ptr_q <= win;
        end
    end

endmodule

// File: rtl/bus_rr_xbar.sv
// Round-robin host-to-device bus crossbar with in-order response tracking.
// Unmapped addresses are routed to an internal error pseudo-target that
// answers one cycle later. Optional per-host grant/stall counters are built
// when BUS_RR_XBAR_PERF_EN is defined.
module bus_rr_xbar
    import bus_rr_pkg::*;
#(
    parameter int unsigned NrHosts        = 2,
    parameter int unsigned NrDevices      = 8,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned AddressWidth   = 32,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic                      clk_sys_i,
    input  logic                      rst_sys_ni,
    input  logic [NrHosts-1:0]        host_req_i,
    output logic [NrHosts-1:0]        host_gnt_o,
    input  logic [AddressWidth-1:0]   host_addr_i [NrHosts],
    input  logic [NrHosts-1:0]        host_we_i,
    input  logic [DataWidth/8-1:0]    host_be_i [NrHosts],
    input  logic [DataWidth-1:0]      host_wdata_i [NrHosts],
    output logic [NrHosts-1:0]        host_rvalid_o,
    output logic [DataWidth-1:0]      host_rdata_o [NrHosts],
    output logic [NrHosts-1:0]        host_err_o,
    output logic [NrDevices-1:0]      device_req_o,
    output logic [AddressWidth-1:0]   device_addr_o [NrDevices],
    output logic [NrDevices-1:0]      device_we_o,
    output logic [DataWidth/8-1:0]    device_be_o [NrDevices],
    output logic [DataWidth-1:0]      device_wdata_o [NrDevices],
    input  logic [NrDevices-1:0]      device_rvalid_i,
    input  logic [DataWidth-1:0]      device_rdata_i [NrDevices],
    input  logic [NrDevices-1:0]      device_err_i,
    input  logic [AddressWidth-1:0]   cfg_device_addr_base [NrDevices],
    input  logic [AddressWidth-1:0]   cfg_device_addr_mask [NrDevices]
`ifdef BUS_RR_XBAR_PERF_EN
    ,
    input  logic                      perf_clr_i,
    output logic [31:0]               perf_gnt_cnt_o [NrHosts],
    output logic [31:0]               perf_stall_cnt_o [NrHosts]
`endif
);

    localparam int unsigned HostW     = idx_width(NrHosts);
    localparam int unsigned PtrW      = idx_width(MaxOutstanding);
    localparam int unsigned CntW      = cnt_width(MaxOutstanding);
    localparam int unsigned ErrTarget = err_target(NrDevices);

    logic [NrHosts-1:0] arb_gnt;
    logic [HostW-1:0]   arb_idx;
    logic               arb_valid;

    idx_t               win_target;
    logic               win_hit;

    out_entry_t         fifo_q [MaxOutstanding];
    logic [PtrW-1:0]    wptr_q;
    logic [PtrW-1:0]    rptr_q;
    logic [CntW-1:0]    count_q;
    idx_t               last_target_q;

    out_entry_t         head;
    logic               head_is_err;
    logic               head_rvalid;
    logic [DataWidth-1:0] head_rdata;
    logic               head_err;
    logic               empty;
    logic               can_push;
    logic               push;
    logic               pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + 1'b1;
    endfunction

    rr_arbiter #(
        .NrHosts (NrHosts)
    ) u_arb (
        .clk_sys_i  (clk_sys_i),
        .rst_sys_ni (rst_sys_ni),
        .req        (host_req_i),
        .advance    (push),
        .gnt        (arb_gnt),
        .idx        (arb_idx),
        .valid      (arb_valid)
    );

    // Decode the candidate's address: lowest matching device wins
    always_comb begin
        win_target = idx_t'(ErrTarget);
        win_hit    = 1'b0;
        for (int unsigned d = 0; d < NrDevices; d++) begin
            if (!win_hit &&
                ((host_addr_i[arb_idx] & cfg_device_addr_mask[d]) == cfg_device_addr_base[d]))
            begin
                win_hit    = 1'b1;
                win_target = idx_t'(d);
            end
        end
    end

    assign head        = fifo_q[rptr_q];
    assign empty       = (count_q == '0);
    assign head_is_err = (head.target == idx_t'(ErrTarget));

    // Select the response lines of the device owing the head entry
    always_comb begin
        head_rvalid = 1'b0;
        head_rdata  = '0;
        head_err    = 1'b0;
        for (int unsigned d = 0; d < NrDevices; d++) begin
            if (head.target == idx_t'(d)) begin
                head_rvalid = device_rvalid_i[d];
                head_rdata  = device_rdata_i[d];
                head_err    = device_err_i[d];
            end
        end
    end

    // A same-cycle pop frees a slot; a target switch waits for a fully drained FIFO
    assign pop      = !empty && (head_is_err || head_rvalid);
    assign can_push = (count_q != CntW'(MaxOutstanding)) || pop;
    assign push     = arb_valid && can_push && (empty || (win_target == last_target_q));

    // Host-side grant and in-order response routing
    always_comb begin
        host_gnt_o    = push ? arb_gnt : '0;
        host_rvalid_o = '0;
        host_err_o    = '0;
        for (int unsigned h = 0; h < NrHosts; h++) begin
            host_rdata_o[h] = '0;
            if (pop && (head.host == idx_t'(h))) begin
                host_rvalid_o[h] = 1'b1;
                host_rdata_o[h]  = head_is_err ? '0 : head_rdata;
                host_err_o[h]    = head_is_err ? 1'b1 : head_err;
            end
        end
    end

    // Device-side request and broadcast of the candidate's fields
    always_comb begin
        device_req_o = '0;
        device_we_o  = '0;
        for (int unsigned d = 0; d < NrDevices; d++) begin
            device_req_o[d]   = push && (win_target == idx_t'(d));
            device_addr_o[d]  = host_addr_i[arb_idx];
            device_we_o[d]    = host_we_i[arb_idx];
            device_be_o[d]    = host_be_i[arb_idx];
            device_wdata_o[d] = host_wdata_i[arb_idx];
        end
    end

    // Response-tracking FIFO with explicit occupancy count
    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            wptr_q        <= '0;
            rptr_q        <= '0;
            count_q       <= '0;
            last_target_q <= '0;
            for (int unsigned i = 0; i < MaxOutstanding; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_q[wptr_q] <= '{host: idx_t'(arb_idx), target: win_target};
                wptr_q         <= ptr_inc(wptr_q);
                last_target_q  <= win_target;
            end
            if (pop) begin
                rptr_q <= ptr_inc(rptr_q);
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

`ifdef BUS_RR_XBAR_PERF_EN
    logic [31:0] gnt_cnt_q   [NrHosts];
    logic [31:0] stall_cnt_q [NrHosts];

    // Saturating per-host grant and stall counters; clear beats increment
    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            for (int unsigned h = 0; h < NrHosts; h++) begin
                gnt_cnt_q[h]   <= '0;
                stall_cnt_q[h] <= '0;
            end
        end else begin
            for (int unsigned h = 0; h < NrHosts; h++) begin
                if (perf_clr_i) begin
                    gnt_cnt_q[h]   <= '0;
                    stall_cnt_q[h] <= '0;
                end else begin
                    if (host_gnt_o[h] && (gnt_cnt_q[h] != '1)) begin
                        gnt_cnt_q[h] <= gnt_cnt_q[h] + 32'd1;
                    end
                    if (host_req_i[h] && !host_gnt_o[h] && (stall_cnt_q[h] != '1)) begin
                        stall_cnt_q[h] <= stall_cnt_q[h] + 32'd1;
                    end
                end
            end
        end
    end

    assign perf_gnt_cnt_o   = gnt_cnt_q;
    assign perf_stall_cnt_o = stall_cnt_q;
`endif

`ifndef SYNTHESIS
    // Stray responses before the first post-reset grant are late answers to
    // requests that the reset discarded, so they are not flagged
    logic                 post_rst_q;
    logic [NrDevices-1:0] expect_rv;

    // Track the window between reset and the first new grant
    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            post_rst_q <= 1'b1;
        end else if (push) begin
            post_rst_q <= 1'b0;
        end
    end

    // Only the device owing the head entry may answer
    always_comb begin
        expect_rv = '0;
        for (int unsigned d = 0; d < NrDevices; d++) begin
            if (!empty && !head_is_err && (head.target == idx_t'(d))) begin
                expect_rv[d] = 1'b1;
            end
        end
    end

    // Flag responses from devices that are not at the FIFO head
    always @(posedge clk_sys_i) begin
        if (rst_sys_ni && !post_rst_q) begin
            assert ((device_rvalid_i & ~expect_rv) == '0)
            else $error("bus_rr_xbar: stray device_rvalid_i %b", device_rvalid_i);
        end
    end
`endif

endmodule
